// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the dmem stb/cyc/resp/retry data port.
// Define RETRY_INJECT_EN to force every 4th in-range request to end in retry.
module dmem_responder #(
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LINE_W      = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       dmem_address,
  input  logic [15:0]       dmem_wdata,
  input  logic [1:0]        dmem_byte_enable,
  input  logic              dmem_write,
  input  logic              dmem_action_stb,
  input  logic              dmem_action_cyc,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              dmem_retry
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t              r_state, w_next;
  logic [14:0]         r_addr;
  logic [15:0]         r_wdata;
  logic [1:0]          r_be;
  logic                r_write;
  logic [CW-1:0]       r_cnt;
  logic                r_resp, r_retry;
  logic [LINE_W-1:0]   r_rdata;
  logic [15:0]         r_mem [DEPTH_WORDS];

  logic                w_accept, w_finish, w_in_range, w_inject, w_ok, w_rej;
  logic [AW-1:0]       w_idx;
  logic [LINE_W-1:0]   w_line;
  logic                w_unused_addr0;

  assign w_unused_addr0 = dmem_address[0];
  assign w_accept   = (r_state == ST_IDLE) && dmem_action_stb && dmem_action_cyc;
  // The DONE-cycle outputs are registered on the edge that enters DONE.
  assign w_finish   = (r_state == ST_WAIT) && dmem_action_cyc && (r_cnt == '0);
  assign w_in_range = 32'(r_addr) < DEPTH_WORDS;
  assign w_idx      = r_addr[AW-1:0];
  assign w_ok       = w_finish && w_in_range && !w_inject;
  assign w_rej      = w_finish && !w_ok;

`ifdef RETRY_INJECT_EN
  logic [1:0] r_inj;
  assign w_inject = (r_inj == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_inj <= '0;
    else if (w_finish && w_in_range) r_inj <= r_inj + 2'd1;
  end
`else
  assign w_inject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WAIT;
      ST_WAIT: begin
        if (!dmem_action_cyc)  w_next = ST_IDLE;
        else if (r_cnt == '0)  w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= dmem_address[15:1];
      r_wdata <= dmem_wdata;
      r_be    <= dmem_byte_enable;
      r_write <= dmem_write;
      r_cnt   <= CW'(LATENCY - 1);
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp  <= 1'b0;
      r_retry <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= w_ok;
      r_retry <= w_rej;
      if (w_ok && !r_write) r_rdata <= w_line;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ok && r_write) begin
      if (r_be[0]) r_mem[w_idx][7:0]  <= r_wdata[7:0];
      if (r_be[1]) r_mem[w_idx][15:8] <= r_wdata[15:8];
    end
  end

  always_comb begin
    w_line = '0;
    for (int unsigned k = 0; k < LINE_W / 16; k++)
      w_line[16*k +: 16] = r_mem[{w_idx[AW-1:3], 3'(k)}];
  end

  assign dmem_rdata = r_rdata;
  assign dmem_resp  = r_resp;
  assign dmem_retry = r_retry;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, hand sequences and a
// randomized run against a word-array reference model.
module tb_dmem_responder;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  dmem_address, dmem_wdata;
  logic [1:0]   dmem_byte_enable;
  logic         dmem_write, dmem_action_stb, dmem_action_cyc;
  logic [127:0] dmem_rdata;
  logic         dmem_resp, dmem_retry;

  dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_write(dmem_write),
    .dmem_action_stb(dmem_action_stb), .dmem_action_cyc(dmem_action_cyc),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_retry(dmem_retry)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [15:0]  mem_m   [DEPTH];
  logic [1:0]   known_m [DEPTH];
  logic [127:0] last_line;
  int           inj_cnt;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        exp_retry;
    logic [15:0] exp_word;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    inj_cnt   = 0;
    last_line = '0;
  endtask

  // One request; abort_at < 0 means keep cyc high, otherwise drop cyc at that WAIT cycle.
  task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                     input logic [1:0] be, input int abort_at, input string nm,
                     output logic o_retry, output logic [127:0] o_line);
    int unsigned  widx, base;
    bit           oor, inj, exp_retry, both;
    int           got_k, pulses;
    logic         got_retry;
    logic [127:0] line, exp_line, mask;
    widx = 32'(addr[15:1]);
    oor  = widx >= DEPTH;
    inj  = 1'b0;
`ifdef RETRY_INJECT_EN
    inj  = !oor && (inj_cnt == 3);
`endif
    exp_retry = oor || inj;

    @(negedge clk);
    dmem_address = addr; dmem_wdata = wd; dmem_byte_enable = be; dmem_write = wr;
    dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
    @(negedge clk);
    dmem_action_stb  = 1'b0;
    dmem_address     = 16'($urandom);
    dmem_wdata       = 16'($urandom);
    dmem_byte_enable = 2'($urandom);
    dmem_write       = ~wr;
    if (abort_at == 0) dmem_action_cyc = 1'b0;

    got_k = -1; pulses = 0; both = 1'b0; got_retry = 1'b0; line = '0;
    for (int k = 1; k <= int'(LAT) + 4; k++) begin
      @(negedge clk);
      if (abort_at > 0 && k == abort_at) dmem_action_cyc = 1'b0;
      if (dmem_resp && dmem_retry) both = 1'b1;
      if (dmem_resp || dmem_retry) begin
        pulses++;
        if (got_k < 0) begin
          got_k = k; got_retry = dmem_retry; line = dmem_rdata;
          dmem_action_cyc = 1'b0;
        end
      end
    end
    dmem_action_cyc = 1'b0;

    chk({nm, " resp&retry"}, 128'(both), 128'(0));
    if (abort_at >= 0) begin
      chk({nm, " pulses_on_abort"}, 128'(pulses), 128'(0));
    end else begin
      chk({nm, " pulses"}, 128'(pulses), 128'(1));
      chk({nm, " latency"}, 128'(got_k), 128'(LAT));
      chk({nm, " is_retry"}, 128'(got_retry), 128'(exp_retry));
      if (exp_retry) begin
        chk({nm, " rdata_held"}, line, last_line);
      end else if (wr) begin
        if (be[0]) begin mem_m[widx][7:0]  = wd[7:0];  known_m[widx][0] = 1'b1; end
        if (be[1]) begin mem_m[widx][15:8] = wd[15:8]; known_m[widx][1] = 1'b1; end
      end else begin
        base = widx & ~32'd7;
        for (int k = 0; k < 8; k++) begin
          exp_line[16*k +: 16] = mem_m[base + k];
          mask[16*k +: 8]      = {8{known_m[base + k][0]}};
          mask[16*k+8 +: 8]    = {8{known_m[base + k][1]}};
        end
        chk({nm, " rdata"}, line & mask, exp_line & mask);
        last_line = exp_line;
      end
      if (!oor) inj_cnt = (inj_cnt + 1) % 4;
    end
    o_retry = got_retry;
    o_line  = line;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [9];
    logic         r;
    logic [127:0] l;
    int           pos;
    logic [15:0]  a;
    bit           exp_inj;

    for (int i = 0; i < int'(DEPTH); i++) begin mem_m[i] = '0; known_m[i] = '0; end
    model_reset();
    rst_n = 1'b0;
    dmem_address = '0; dmem_wdata = '0; dmem_byte_enable = '0; dmem_write = 1'b0;
    dmem_action_stb = 1'b0; dmem_action_cyc = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("reset_idle%0d resp", i), 128'(dmem_resp), 128'(0));
      chk($sformatf("reset_idle%0d retry", i), 128'(dmem_retry), 128'(0));
      chk($sformatf("reset_idle%0d rdata", i), dmem_rdata, 128'(0));
      if (i == 1) rst_n = 1'b1;
    end

    tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 16'hBEEF};
    tbl[2] = '{1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 16'h0020, 16'hAB00, 2'b10, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 16'hAB34};
    tbl[5] = '{1'b0, 16'hFFFE, 16'h0000, 2'b00, 1'b1, 16'h0000};
    tbl[6] = '{1'b1, 16'h0030, 16'hCAFE, 2'b11, 1'b0, 16'h0000};
    tbl[7] = '{1'b1, 16'h0030, 16'h1111, 2'b00, 1'b0, 16'h0000};
    tbl[8] = '{1'b0, 16'h0031, 16'h0000, 2'b00, 1'b0, 16'hCAFE};
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, -1, $sformatf("tbl%0d", i), r, l);
`ifndef RETRY_INJECT_EN
      chk($sformatf("tbl%0d retry", i), 128'(r), 128'(tbl[i].exp_retry));
      if (!tbl[i].wr && !tbl[i].exp_retry) begin
        pos = int'(tbl[i].addr[3:1]);
        chk($sformatf("tbl%0d word", i), 128'(l[16*pos +: 16]), 128'(tbl[i].exp_word));
      end
`endif
    end

    for (int w = 0; w < 64; w++)
      txn(1'b1, 16'(w * 2), 16'($urandom), 2'b11, -1, "preload", r, l);

    txn(1'b1, 16'h0040, 16'h5555, 2'b11, 0, "abort_wr", r, l);
    txn(1'b0, 16'h0040, 16'h0000, 2'b00, -1, "abort_rd", r, l);

    @(negedge clk);
    dmem_address = 16'h0042; dmem_wdata = 16'h7777; dmem_byte_enable = 2'b11;
    dmem_write = 1'b1; dmem_action_stb = 1'b1; dmem_action_cyc = 1'b1;
    @(negedge clk);
    dmem_action_stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst resp", 128'(dmem_resp), 128'(0));
    chk("async_rst retry", 128'(dmem_retry), 128'(0));
    chk("async_rst rdata", dmem_rdata, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      @(negedge clk);
      chk($sformatf("async_rst quiet%0d", k), 128'({dmem_resp, dmem_retry}), 128'(0));
    end
    dmem_action_cyc = 1'b0;
    model_reset();
    txn(1'b0, 16'h0042, 16'h0000, 2'b00, -1, "async_rst_rd", r, l);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(16'h2000, 16'hFFFF));
      else                           a = 16'(($urandom_range(0, 63) << 1) | $urandom_range(0, 1));
      txn(1'($urandom), a, 16'($urandom), 2'($urandom),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LAT - 1)) : -1,
          $sformatf("rnd%0d", i), r, l);
    end

`ifdef RETRY_INJECT_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, 16'($urandom_range(0, 63) << 1), 16'h0000, 2'b00, -1, $sformatf("inj%0d", i), r, l);
      exp_inj = ((i % 4) == 3);
      chk($sformatf("inj%0d pattern", i), 128'(r), 128'(exp_inj));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
